// File: rtl/blowfish_iter_core.sv
// Iterative Blowfish core: one Feistel round per clock, NBLK 64-bit lanes processed in sequence.
// Subkeys live in a writable P-array and four S-boxes that can only be loaded while idle.
module blowfish_iter_core #(
  parameter int NBLK   = 2,
  parameter int ROUNDS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_we,
  input  logic [2:0]           key_sel,
  input  logic [7:0]           key_addr,
  input  logic [31:0]          key_wdata,
  output logic                 key_err,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [64*NBLK-1:0]   in_data,
  input  logic                 mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [64*NBLK-1:0]   out_data
);

  localparam int W  = 64 * NBLK;
  localparam int PN = ROUNDS + 2;
  localparam int PW = $clog2(PN);
  localparam int LW = (NBLK > 1) ? $clog2(NBLK) : 1;

  localparam logic [PW-1:0] PLAST = PW'(ROUNDS + 1);
  localparam logic [PW-1:0] PPEN  = PW'(ROUNDS);
  localparam logic [PW-1:0] RLAST = PW'(ROUNDS - 1);
  localparam logic [LW-1:0] LLAST = LW'(NBLK - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic [PW-1:0] round;
  logic [LW-1:0] lane;
  logic          md;
  logic [31:0]   xl, xr;
  logic [W-1:0]  din;
  logic [W-1:0]  res;

  logic [31:0] p  [PN];
  logic [31:0] s0 [256];
  logic [31:0] s1 [256];
  logic [31:0] s2 [256];
  logic [31:0] s3 [256];

  logic          key_bad;
  logic [PW-1:0] pidx;
  logic [31:0]   t, f, pa, pb;
  logic [63:0]   fin;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  // Writes are refused outside IDLE so a running operation always sees a frozen key set.
  assign key_bad = (state != S_IDLE) || (key_sel > 3'd4) ||
                   ((key_sel == 3'd0) && (key_addr > 8'(ROUNDS + 1)));

  always_ff @(posedge clk) begin
    if (rst && key_we && !key_bad) begin
      case (key_sel)
        3'd0:    p[key_addr[PW-1:0]] <= key_wdata;
        3'd1:    s0[key_addr] <= key_wdata;
        3'd2:    s1[key_addr] <= key_wdata;
        3'd3:    s2[key_addr] <= key_wdata;
        3'd4:    s3[key_addr] <= key_wdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    pidx = md ? (PLAST - round) : round;
    t    = xl ^ p[pidx];
    f    = ((s0[t[31:24]] + s1[t[23:16]]) ^ s2[t[15:8]]) + s3[t[7:0]];
    pa   = md ? p[PW'(1)] : p[PPEN];
    pb   = md ? p[PW'(0)] : p[PLAST];
    // Output whitening with the last swap undone: new xL comes from xR and vice versa.
    fin  = {xr ^ pb, xl ^ pa};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      round    <= '0;
      lane     <= '0;
      md       <= 1'b0;
      xl       <= '0;
      xr       <= '0;
      din      <= '0;
      res      <= '0;
      out_data <= '0;
      key_err  <= 1'b0;
    end else begin
      key_err <= key_we && key_bad;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            md    <= mode;
            xl    <= in_data[W-1 -: 32];
            xr    <= in_data[W-33 -: 32];
            din   <= in_data << 64;
            lane  <= '0;
            round <= '0;
            state <= S_ROUND;
          end
        end
        S_ROUND: begin
          xl    <= xr ^ f;
          xr    <= t;
          round <= round + 1'b1;
          if (round == RLAST) state <= S_FINAL;
        end
        S_FINAL: begin
          round <= '0;
          // Lane results shift in from the bottom so lane 0 ends up in the top slot.
          if (lane == LLAST) begin
            out_data <= (res << 64) | W'(fin);
            state    <= S_DONE;
          end else begin
            res   <= (res << 64) | W'(fin);
            lane  <= lane + 1'b1;
            xl    <= din[W-1 -: 32];
            xr    <= din[W-33 -: 32];
            din   <= din << 64;
            state <= S_ROUND;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/blowfish_iter_core.md
BLOWFISH_ITER_CORE -- requirements
Module: blowfish_iter_core

Interface
REQ-001 Parameter NBLK, default 2: number of 64-bit Blowfish blocks per data word; legal range 1..4.
REQ-002 Parameter ROUNDS, default 16: Feistel rounds per block; even, at least 2; the P-array holds ROUNDS+2 entries.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 Port key_we, input, 1 bit: subkey write strobe.
REQ-006 Port key_sel, input, 3 bits: 0 selects the P-array; 1..4 select S-boxes S0..S3; 5..7 are reserved.
REQ-007 Port key_addr, input, 8 bits: entry index.
REQ-008 Port key_wdata, input, 32 bits: subkey value to write.
REQ-009 Port key_err, output, 1 bit: one-cycle pulse flagging a rejected write.
REQ-010 Port in_valid, input, 1 bit; port in_ready, output, 1 bit: input handshake.
REQ-011 Port in_data, input, 64*NBLK bits: input word.
REQ-012 Port mode, input, 1 bit: 0 = encrypt, 1 = decrypt; sampled only on the accept cycle.
REQ-013 Port out_valid, output, 1 bit; port out_ready, input, 1 bit: output handshake.
REQ-014 Port out_data, output, 64*NBLK bits: result word.

Function
REQ-015 Subkey store: P[0..ROUNDS+1] and S0..S3 of 256x32 each, with combinational read.
- A write occurs only when key_we=1 and the FSM is in IDLE.
- key_we in any other state, a key_sel value of 5..7, or P key_addr > ROUNDS+1 drops the write and pulses key_err for 1 cycle.
REQ-016 FSM states IDLE, ROUND, FINAL, DONE.
- in_ready=1 only in IDLE.
- The accept cycle is in_valid & in_ready; on it the core latches in_data and mode, sets lane=0, round=0, and moves to ROUND.
REQ-017 Lane k is in_data[64*(NBLK-k)-1 -: 64]; lanes run in order 0..NBLK-1.
- Within a lane, xL is the upper 32 bits and xR the lower 32 bits.
REQ-018 Round function: F(x) = ((S0[x[31:24]] + S1[x[23:16]]) ^ S2[x[15:8]]) + S3[x[7:0]], with both additions modulo 2^32.
REQ-019 Each ROUND cycle performs t = xL ^ Pi, then xL <= xR ^ F(t), xR <= t.
- Pi = P[round] when encrypting and P[ROUNDS+1-round] when decrypting.
- round increments each cycle; at round = ROUNDS-1 the FSM moves to FINAL.
REQ-020 FINAL, one cycle:
- Undo the last swap, then xR ^= Pa and xL ^= Pb.
- Encrypt: Pa = P[ROUNDS], Pb = P[ROUNDS+1]. Decrypt: Pa = P[1], Pb = P[0].
- Store {xL,xR} into the lane k slot of the result.
- If lane < NBLK-1: lane++, round=0, load the next lane, return to ROUND. Otherwise go to DONE.
REQ-021 Latency: out_valid rises exactly NBLK*(ROUNDS+1) cycles after the accept edge; for the defaults this is 34 cycles.
REQ-022 In DONE, out_valid=1 and out_data holds stable until out_valid & out_ready, then the FSM returns to IDLE.
- No input is accepted in the same cycle as the release.
REQ-023 out_data changes only on entry to DONE; it is never partially updated while visible.
REQ-024 A subkey write cannot alter an operation in flight; this is guaranteed by REQ-015.

Reset
REQ-025 While rst=0 on a clock edge:
- FSM goes to IDLE; in_ready=1 from the next cycle.
- out_valid=0, out_data=0, key_err=0.
- Lane and round counters and xL/xR are cleared.
REQ-026 Reset mid-operation discards the operation silently; no out_valid is produced for it.
REQ-027 The subkey store is not cleared by reset; its contents are undefined until written.

Verification
REQ-028 Zero subkeys, NBLK=2: all P and S entries written 0; encrypt in_data=0x0123456789ABCDEF_FEDCBA9876543210 -> out_data=0x89ABCDEF01234567_76543210FEDCBA98, out_valid 34 cycles after accept.
REQ-029 Standard vector: subkeys expanded by the software model from the 64-bit all-zero key.
- Encrypt a 0 word -> each lane 0x4EF997456198DD78.
- Decrypt that result -> 0.
REQ-030 Second standard vector: key 0xFFFFFFFFFFFFFFFF with plaintext lanes 0xFFFFFFFFFFFFFFFF -> each lane 0x51866FD5B85ECB8A; mode is flipped after the accept cycle with no effect on the result.
REQ-031 Backpressure: hold out_ready=0 for 10 cycles after out_valid.
- out_data stays stable and in_ready stays 0.
- On the release cycle the FSM goes to IDLE, and in_ready=1 on the next cycle.
REQ-032 Rejected writes:
- key_we during ROUND -> key_err pulse, and the result is unchanged versus the golden value.
- key_sel=6 in IDLE -> key_err pulse and no store update.
REQ-033 Reset mid-operation: rst=0 on round 5 of lane 1.
- Next cycle: out_valid=0, in_ready=1, out_data=0.
- A fresh operation then completes with the correct vector.
